// File: rtl/spectrum_pkg.sv
// Shared constants and capture FSM states for the spectrum datapath.
// Imported by the I2S capture front end and its helpers.
package spectrum_pkg;

  localparam int SAMPLE_BITS      = 16;
  localparam int BUFFER_ADDR_BITS = 8;
  localparam int RAM_ADDR_BITS    = BUFFER_ADDR_BITS + 1;
  localparam int OUT_BITS         = 8;

  typedef enum logic [1:0] {
    WAIT_LR,
    DELAY,
    SHIFT,
    WRITE
  } cap_state_e;

endpackage

// File: rtl/sync_edge_detect.sv
// Two-flop synchroniser for an asynchronous level.
// Emits a one-cycle strobe on its synchronised rising edge.
module sync_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic async_i,
  output logic rise_o
);

  logic meta;
  logic sync;
  logic prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b0;
      sync <= 1'b0;
      prev <= 1'b0;
    end else begin
      meta <= async_i;
      sync <= meta;
      prev <= sync;
    end
  end

  assign rise_o = sync & ~prev;

endmodule

// File: rtl/i2s_capture_pingpong.sv
// Left-channel I2S capture into a ping-pong sample RAM.
// Swaps halves on each full frame and flags dropped frames.
module i2s_capture_pingpong
  import spectrum_pkg::*;
#(
  parameter int SAMPLE_BITS      = spectrum_pkg::SAMPLE_BITS,
  parameter int BUFFER_ADDR_BITS = spectrum_pkg::BUFFER_ADDR_BITS,
  parameter int OUT_BITS         = spectrum_pkg::OUT_BITS
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      enable_i,
  input  logic                      bclk_i,
  input  logic                      adclrck_i,
  input  logic                      adcdat_i,
  output logic                      ram_wr_en_o,
  output logic [BUFFER_ADDR_BITS:0] ram_wr_addr_o,
  output logic [OUT_BITS-1:0]       ram_wr_data_o,
  output logic                      rd_buf_sel_o,
  output logic                      frame_ready_o,
  input  logic                      frame_ack_i,
  output logic                      overrun_o,
  output logic [7:0]                overrun_cnt_o
);

  localparam int CW = $clog2(SAMPLE_BITS + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(SAMPLE_BITS);
  localparam logic [BUFFER_ADDR_BITS-1:0] LAST_IDX = '1;

  logic                        bclk_rise;
  logic [1:0]                  lr_ff;
  logic [1:0]                  dat_ff;
  logic                        lrck;
  logic                        dat;
  logic                        lr_prev;
  cap_state_e                  state;
  logic [SAMPLE_BITS-1:0]      shreg;
  logic [CW-1:0]               bitcnt;
  logic [BUFFER_ADDR_BITS-1:0] idx;

  sync_edge_detect u_bclk (
    .clk     (clk),
    .rst     (rst),
    .async_i (bclk_i),
    .rise_o  (bclk_rise)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      lr_ff  <= '0;
      dat_ff <= '0;
    end else begin
      lr_ff  <= {lr_ff[0], adclrck_i};
      dat_ff <= {dat_ff[0], adcdat_i};
    end
  end

  assign lrck = lr_ff[1];
  assign dat  = dat_ff[1];

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= WAIT_LR;
      lr_prev       <= 1'b0;
      shreg         <= '0;
      bitcnt        <= '0;
      idx           <= '0;
      ram_wr_en_o   <= 1'b0;
      ram_wr_addr_o <= '0;
      ram_wr_data_o <= '0;
      rd_buf_sel_o  <= 1'b0;
      frame_ready_o <= 1'b0;
      overrun_o     <= 1'b0;
      overrun_cnt_o <= '0;
    end else begin
      ram_wr_en_o <= 1'b0;
      overrun_o   <= 1'b0;
      if (bclk_rise)
        lr_prev <= lrck;
      if (frame_ack_i)
        frame_ready_o <= 1'b0;
      if (!enable_i) begin
        state  <= WAIT_LR;
        idx    <= '0;
        bitcnt <= '0;
      end else begin
        unique case (state)
          WAIT_LR: begin
            if (bclk_rise && !lrck && lr_prev)
              state <= DELAY;
          end
          DELAY: begin
            if (bclk_rise) begin
              shreg  <= {shreg[SAMPLE_BITS-2:0], dat};
              bitcnt <= CW'(1);
              state  <= SHIFT;
            end
          end
          SHIFT: begin
            if (bitcnt == FULL_CNT) begin
              state         <= WRITE;
              ram_wr_en_o   <= 1'b1;
              ram_wr_addr_o <= {~rd_buf_sel_o, idx};
              ram_wr_data_o <= shreg[SAMPLE_BITS-1 -: OUT_BITS];
            end else if (bclk_rise) begin
              // LR toggled early: truncated word is dropped
              if (lrck) begin
                state <= WAIT_LR;
              end else begin
                shreg  <= {shreg[SAMPLE_BITS-2:0], dat};
                bitcnt <= bitcnt + 1'b1;
              end
            end
          end
          WRITE: begin
            idx   <= idx + 1'b1;
            state <= WAIT_LR;
            if (idx == LAST_IDX) begin
              if (!frame_ready_o || frame_ack_i) begin
                rd_buf_sel_o  <= ~rd_buf_sel_o;
                frame_ready_o <= 1'b1;
              end else begin
                overrun_o <= 1'b1;
                if (overrun_cnt_o != 8'hFF)
                  overrun_cnt_o <= overrun_cnt_o + 1'b1;
              end
            end
          end
          default: state <= WAIT_LR;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2s_capture_pingpong.sv
// Directed/random bench for i2s_capture_pingpong.
// Frame bookkeeping is modelled as plain index/half arithmetic.
module tb_i2s_capture_pingpong;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable_i;
  logic       bclk_i;
  logic       adclrck_i;
  logic       adcdat_i;
  logic       frame_ack_i;
  logic       ram_wr_en_o;
  logic [8:0] ram_wr_addr_o;
  logic [7:0] ram_wr_data_o;
  logic       rd_buf_sel_o;
  logic       frame_ready_o;
  logic       overrun_o;
  logic [7:0] overrun_cnt_o;

  i2s_capture_pingpong dut (
    .clk           (clk),
    .rst           (rst),
    .enable_i      (enable_i),
    .bclk_i        (bclk_i),
    .adclrck_i     (adclrck_i),
    .adcdat_i      (adcdat_i),
    .ram_wr_en_o   (ram_wr_en_o),
    .ram_wr_addr_o (ram_wr_addr_o),
    .ram_wr_data_o (ram_wr_data_o),
    .rd_buf_sel_o  (rd_buf_sel_o),
    .frame_ready_o (frame_ready_o),
    .frame_ack_i   (frame_ack_i),
    .overrun_o     (overrun_o),
    .overrun_cnt_o (overrun_cnt_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [8:0] a;
    logic [7:0] d;
    int         c;
  } wr_t;

  wr_t wq[$];
  int  ovr_seen = 0;

  always @(negedge clk) begin
    if (ram_wr_en_o === 1'b1)
      wq.push_back('{ram_wr_addr_o, ram_wr_data_o, cyc});
    if (overrun_o === 1'b1)
      ovr_seen++;
  end

  int checks = 0;
  int failures = 0;
  int hp = 2;
  int lslot = 17;
  int rslot = 1;
  int lsb_cyc = 0;
  int rise_cyc = 0;

  int m_idx = 0;
  int m_ovr = 0;
  int m_cnt = 0;
  bit m_sel = 1'b0;
  bit m_ready = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic slot_bit(input logic [15:0] v, input int i);
    if (i >= 1 && i <= 16)
      return v[16-i];
    return 1'b0;
  endfunction

  task automatic send_bit(input logic lr, input logic d);
    bclk_i = 1'b0;
    adclrck_i = lr;
    adcdat_i = d;
    repeat (hp) @(negedge clk);
    bclk_i = 1'b1;
    rise_cyc = cyc;
    repeat (hp) @(negedge clk);
  endtask

  task automatic send_pair(input logic [15:0] lv, input logic [15:0] rv);
    for (int i = 0; i < lslot; i++) begin
      send_bit(1'b0, slot_bit(lv, i));
      if (i == 16)
        lsb_cyc = rise_cyc;
    end
    for (int i = 0; i < rslot; i++)
      send_bit(1'b1, slot_bit(rv, i));
  endtask

  task automatic model_word(input bit ack, output logic [8:0] ea);
    ea = m_sel ? 9'(m_idx) : 9'(256 + m_idx);
    if (m_idx == 255) begin
      m_idx = 0;
      if (!m_ready || ack) begin
        m_sel = !m_sel;
        m_ready = 1'b1;
      end else begin
        m_ovr++;
        if (m_cnt < 255)
          m_cnt++;
      end
    end else begin
      m_idx++;
    end
  endtask

  task automatic expect_write(input string tag, input logic [8:0] ea,
                              input logic [7:0] ed);
    wr_t w;
    chk({tag, " count"}, 32'(wq.size()), 32'd1);
    if (wq.size() > 0) begin
      w = wq.pop_front();
      chk({tag, " addr"}, 32'(w.a), 32'(ea));
      chk({tag, " data"}, 32'(w.d), 32'(ed));
    end
    wq.delete();
  endtask

  task automatic word(input logic [15:0] v, input string tag);
    logic [8:0] ea;
    model_word(1'b0, ea);
    send_pair(v, 16'($urandom));
    expect_write(tag, ea, v[15:8]);
  endtask

  task automatic check_status(input string tag);
    chk({tag, " sel"}, 32'(rd_buf_sel_o), 32'(m_sel));
    chk({tag, " ready"}, 32'(frame_ready_o), 32'(m_ready));
    chk({tag, " ovr_cnt"}, 32'(overrun_cnt_o), 32'(m_cnt));
    chk({tag, " ovr_pulses"}, 32'(ovr_seen), 32'(m_ovr));
  endtask

  task automatic reset_and_check(input string tag);
    rst = 1'b1;
    @(negedge clk);
    chk({tag, " wr_en"}, 32'(ram_wr_en_o), 32'd0);
    chk({tag, " addr"}, 32'(ram_wr_addr_o), 32'd0);
    chk({tag, " data"}, 32'(ram_wr_data_o), 32'd0);
    chk({tag, " sel"}, 32'(rd_buf_sel_o), 32'd0);
    chk({tag, " ready"}, 32'(frame_ready_o), 32'd0);
    chk({tag, " overrun"}, 32'(overrun_o), 32'd0);
    chk({tag, " ovr_cnt"}, 32'(overrun_cnt_o), 32'd0);
    rst = 1'b0;
    m_idx = 0;
    m_sel = 1'b0;
    m_ready = 1'b0;
    m_cnt = 0;
    m_ovr = 0;
    ovr_seen = 0;
    wq.delete();
  endtask

  initial begin
    logic [15:0] v;
    logic [8:0]  ea;
    int          k;

    rst = 1'b1;
    enable_i = 1'b1;
    bclk_i = 1'b0;
    adclrck_i = 1'b1;
    adcdat_i = 1'b0;
    frame_ack_i = 1'b0;
    repeat (3) @(negedge clk);
    reset_and_check("reset0");

    // single slow word pair: 32-bit slots, clk = 20x bclk
    hp = 10;
    lslot = 32;
    rslot = 32;
    send_bit(1'b1, 1'b0);
    model_word(1'b0, ea);
    send_pair(16'hA5C3, 16'h1234);
    chk("t1 latency", (wq.size() > 0) ? 32'(wq[0].c - lsb_cyc) : 32'hFFFF_FFFF,
        32'd4);
    expect_write("t1", ea, 8'hA5);

    reset_and_check("reset1");
    hp = 2;
    lslot = 17;
    rslot = 1;
    send_bit(1'b1, 1'b0);

    for (int n = 0; n < 256; n++)
      word({8'(n), 8'($urandom)}, "f1");
    check_status("f1 done");

    // no ack: this completion must be dropped as an overrun
    for (int n = 0; n < 256; n++)
      word(16'($urandom), "f2");
    check_status("f2 done");

    for (int n = 0; n < 255; n++)
      word(16'($urandom), "f3");
    v = 16'($urandom);
    model_word(1'b1, ea);
    fork
      send_pair(v, 16'h0000);
      begin
        k = 0;
        while (ram_wr_en_o !== 1'b1 && k < 200) begin
          @(negedge clk);
          k++;
        end
        chk("f3 ack aligned", 32'(ram_wr_en_o), 32'd1);
        frame_ack_i = 1'b1;
        @(negedge clk);
        frame_ack_i = 1'b0;
      end
    join
    expect_write("f3 last", ea, v[15:8]);
    check_status("f3 done");

    frame_ack_i = 1'b1;
    @(negedge clk);
    frame_ack_i = 1'b0;
    m_ready = 1'b0;
    chk("ack clears ready", 32'(frame_ready_o), 32'(m_ready));
    frame_ack_i = 1'b1;
    @(negedge clk);
    frame_ack_i = 1'b0;
    @(negedge clk);
    check_status("idle ack");

    word(16'($urandom), "en pre");
    v = 16'($urandom);
    for (int i = 0; i <= 10; i++)
      send_bit(1'b0, slot_bit(v, i));
    enable_i = 1'b0;
    m_idx = 0;
    for (int i = 11; i <= 16; i++)
      send_bit(1'b0, slot_bit(v, i));
    send_bit(1'b1, 1'b0);
    chk("en aborted count", 32'(wq.size()), 32'd0);
    check_status("en off");
    enable_i = 1'b1;
    word(16'($urandom), "en resume");

    for (int n = 0; n < 99; n++)
      word(16'($urandom), "pre rst");
    v = 16'($urandom);
    for (int i = 0; i <= 8; i++)
      send_bit(1'b0, slot_bit(v, i));
    reset_and_check("reset mid");
    for (int i = 9; i <= 16; i++)
      send_bit(1'b0, slot_bit(v, i));
    send_bit(1'b1, 1'b0);
    chk("rst aborted count", 32'(wq.size()), 32'd0);
    word(16'($urandom), "after rst");
    check_status("final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
